// File: rtl/pipereg_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer.
// in_ready is registered, so no combinational ready path crosses the stage.
// An empty stage presents a bubble (NOP in field 0, zeros elsewhere).
// kill_count is a saturating count of the valid entries that flushes destroyed.
module pipereg_skid_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_FIELDS = 3,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_WORD = DATA_WIDTH'(32'h00000013),
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_FIELDS*DATA_WIDTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_FIELDS*DATA_WIDTH-1:0] out_data,
    output logic [1:0]                       occupancy,
    output logic [STAT_WIDTH-1:0]            kill_count
);

    localparam int unsigned BUS_W = NUM_FIELDS * DATA_WIDTH;
    localparam int unsigned SUM_W = STAT_WIDTH + 1;
    localparam logic [BUS_W-1:0] BUBBLE_BUS = BUS_W'(BUBBLE_WORD);
    localparam logic [STAT_WIDTH-1:0] KILL_MAX = '1;

    // The state encoding is the occupancy value itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BUS_W-1:0]    main_q, main_d;
    logic [BUS_W-1:0]    skid_q, skid_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [STAT_WIDTH-1:0] kill_q, kill_d;
    logic [SUM_W-1:0]    kill_sum;
    logic [1:0]          killed;
    logic                accept;
    logic                fire;

    // Registered state, storage and status; main holds the bubble whenever it is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_BUS;
            skid_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            kill_q  <= kill_d;
        end
    end

    // Next state, next storage contents and the flush kill accounting.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        kill_d   = kill_q;
        kill_sum = '0;
        killed   = 2'd0;
        accept   = in_valid & ready_q;
        fire     = (state_q != EMPTY) & out_ready;

        if (flush) begin
            // A fired head entry leaves normally and is not counted as killed.
            state_d = EMPTY;
            main_d  = BUBBLE_BUS;
            skid_d  = '0;
            case (state_q)
                ONE:     killed = fire ? 2'd0 : 2'd1;
                FULL:    killed = fire ? 2'd1 : 2'd2;
                default: killed = 2'd0;
            endcase
            kill_sum = {1'b0, kill_q} + SUM_W'(killed);
            kill_d   = kill_sum[STAT_WIDTH] ? KILL_MAX : kill_sum[STAT_WIDTH-1:0];
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (fire) begin
                        main_d  = BUBBLE_BUS;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_BUS;
                    skid_d  = '0;
                end
            endcase
        end

        ready_d = (state_d != FULL);
        valid_d = (state_d != EMPTY);
    end

    assign in_ready   = ready_q;
    assign out_valid  = valid_q;
    assign out_data   = main_q;
    assign occupancy  = state_q;
    assign kill_count = kill_q;

endmodule

// File: tb/tb_pipereg_skid_stage.sv
// Scoreboard bench for pipereg_skid_stage: a queue of held entries is the reference.
module tb_pipereg_skid_stage;

    localparam logic [95:0] BUBBLE = 96'h13;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [95:0] in_data;

    logic        in_ready,  out_valid;
    logic [95:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] kill_count;

    logic        sat_in_ready, sat_out_valid;
    logic [95:0] sat_out_data;
    logic [1:0]  sat_occupancy;
    logic [1:0]  sat_kill_count;

    logic [95:0] q[$];
    int          kill_m;
    int          sat_m;
    bit          chk;
    int          n_tests;
    int          n_fail;

    always #5 clk = ~clk;

    pipereg_skid_stage u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .kill_count (kill_count)
    );

    // Same stimulus, narrow counter for the saturation case.
    pipereg_skid_stage #(.STAT_WIDTH(2)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (sat_in_ready),
        .in_data    (in_data),
        .out_valid  (sat_out_valid),
        .out_ready  (out_ready),
        .out_data   (sat_out_data),
        .occupancy  (sat_occupancy),
        .kill_count (sat_kill_count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [95:0] entry(input logic [31:0] pc);
        return {pc + 32'd4, pc, 32'hC0DE_0000 | pc};
    endfunction

    // One clock: drive at the falling edge, compare against the model, advance the model.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic ordy,
                         input logic fl, input logic rs);
        logic [95:0] exp_data;
        bit acc;
        bit fr;
        int k;
        rst       = rs;
        flush     = fl;
        in_valid  = v;
        in_data   = entry(pc);
        out_ready = ordy;
        exp_data  = (q.size() > 0) ? q[0] : BUBBLE;
        if (chk) begin
            check("out_valid", 128'(out_valid), 128'(q.size() > 0));
            check("occupancy", 128'(occupancy), 128'(q.size()));
            check("in_ready",  128'(in_ready),  128'(q.size() < 2));
            check("out_data",  128'(out_data),  128'(exp_data));
            check("kill_count", 128'(kill_count), 128'(kill_m));
            check("sat_kill",  128'(sat_kill_count), 128'(sat_m));
            check("sat_view",  128'({sat_in_ready, sat_out_valid, sat_occupancy}),
                  128'({q.size() < 2, q.size() > 0, 2'(q.size())}));
            check("sat_data",  128'(sat_out_data), 128'(exp_data));
        end
        acc = v && (q.size() < 2);
        fr  = (q.size() > 0) && ordy;
        @(posedge clk);
        if (rs) begin
            q.delete();
            kill_m = 0;
            sat_m  = 0;
            chk    = 1'b1;
        end else begin
            if (fr) void'(q.pop_front());
            if (fl) begin
                k = q.size();
                q.delete();
                kill_m = (kill_m + k > 65535) ? 65535 : kill_m + k;
                sat_m  = (sat_m + k > 3) ? 3 : sat_m + k;
            end else if (acc) begin
                q.push_back(entry(pc));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk     = 1'b0;
        kill_m  = 0;
        sat_m   = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(negedge clk);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Stream with out_ready held high: one entry in flight, in order.
        for (int i = 0; i < 8; i++) cycle(1, 32'(4 * i), 1, 0, 0);
        check("stream_occ", 128'(occupancy), 128'(1));
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0);

        // Stall: A and B fill the stage, C is refused, A is held, then drain in order.
        cycle(1, 32'h100, 0, 0, 0);
        cycle(1, 32'h104, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 32'h108, 0, 0, 0);
        check("stall_head", 128'(out_data), 128'(entry(32'h100)));
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);

        // Flush a full, stalled stage with a concurrent input.
        cycle(1, 32'h200, 0, 0, 0);
        cycle(1, 32'h204, 0, 0, 0);
        cycle(1, 32'h208, 0, 1, 0);
        check("flush_kill", 128'(kill_count), 128'(2));
        check("flush_bubble", 128'(out_data[31:0]), 128'(32'h13));
        cycle(0, 0, 0, 0, 0);

        // Flush with a concurrent fire: the entry leaves, the count stays.
        cycle(1, 32'h300, 0, 0, 0);
        cycle(0, 0, 1, 1, 0);
        check("fire_flush_kill", 128'(kill_count), 128'(2));
        cycle(0, 0, 1, 0, 0);

        // Saturation on the 2-bit counter after three full flushes.
        cycle(0, 0, 0, 0, 1);
        for (int r = 0; r < 3; r++) begin
            cycle(1, 32'(32'h400 + 16 * r), 0, 0, 0);
            cycle(1, 32'(32'h404 + 16 * r), 0, 0, 0);
            cycle(0, 0, 0, 1, 0);
        end
        check("sat_final", 128'(sat_kill_count), 128'(3));
        check("wide_final", 128'(kill_count), 128'(6));
        cycle(0, 0, 0, 0, 0);

        // Reset while full and stalled, then restart a stream.
        cycle(1, 32'h500, 0, 0, 0);
        cycle(1, 32'h504, 0, 0, 0);
        cycle(1, 32'h508, 0, 0, 1);
        check("rst_kill", 128'(kill_count), 128'(0));
        for (int i = 0; i < 4; i++) cycle(1, 32'(32'h600 + 4 * i), 1, 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0);
        check("drained", 128'(q.size() == 0 && out_valid == 1'b0), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
